// File: rtl/logarithmic_afpm.sv
// Approximate FP16 multiplier (Mitchell logarithmic approximation) with a
// byte-serial interface. A free-running phase counter, started by reset
// release, frames operand capture and result output. There is no handshake.
module logarithmic_afpm #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned LAST = 3 * HOLD_CYCLES;
  localparam int unsigned CW   = $clog2(LAST + 1);

  localparam logic [CW-1:0] CNT_LO_CAP = '0;
  localparam logic [CW-1:0] CNT_HI_CAP = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_HI_OUT = CW'(2 * HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(LAST);

  logic [CW-1:0] cnt;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic [15:0]   r_q;
  logic [7:0]    out_q;

  // Combinational product signals
  logic              sa, sb, sr;
  logic [4:0]        ea, eb;
  logic [9:0]        fa, fb;
  logic [10:0]       fsum;
  logic signed [7:0] er;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [15:0]       prod;

  assign uio_out = '0;
  assign uio_oe  = '0;
  assign uo_out  = out_q;

  // ena has no function; the low result byte is only ever sent from prod.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, r_q[7:0]};

  // Free-running phase counter, 0..3*HOLD_CYCLES then wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Operand capture: low bytes at phase 0, high bytes at phase HOLD_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (cnt == CNT_LO_CAP) begin
      a_q[7:0] <= ui_in;
      b_q[7:0] <= uio_in;
    end else if (cnt == CNT_HI_CAP) begin
      a_q[15:8] <= ui_in;
      b_q[15:8] <= uio_in;
    end
  end

  // Result load and byte-serial output; uo_out holds the high byte until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      out_q <= '0;
    end else if (cnt == CNT_LOAD) begin
      r_q   <= prod;
      out_q <= prod[7:0];
    end else if (cnt == CNT_HI_OUT) begin
      out_q <= r_q[15:8];
    end
  end

  // Field split, Mitchell mantissa add, exponent sum and special-case priority
  always_comb begin
    sa = a_q[15];
    sb = b_q[15];
    ea = a_q[14:10];
    eb = b_q[14:10];
    fa = a_q[9:0];
    fb = b_q[9:0];
    sr = sa ^ sb;

    a_nan  = (ea == 5'h1F) && (fa != '0);
    b_nan  = (eb == 5'h1F) && (fb != '0);
    a_inf  = (ea == 5'h1F) && (fa == '0);
    b_inf  = (eb == 5'h1F) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    // Mantissa carry bumps the exponent; the sum bits become the fraction
    fsum = {1'b0, fa} + {1'b0, fb};
    er   = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15
         + $signed({7'b0000000, fsum[10]});

    prod = '0;
    if (a_nan || b_nan) begin
      prod = 16'h7E00;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      prod = 16'h7E00;
    end else if (a_inf || b_inf) begin
      prod = {sr, 5'h1F, 10'h000};
    end else if (a_zero || b_zero) begin
      prod = {sr, 15'h0000};
    end else if (er >= 8'sd31) begin
      prod = {sr, 5'h1F, 10'h000};
    end else if (er <= 8'sd0) begin
      prod = {sr, 15'h0000};
    end else begin
      prod = {sr, er[4:0], fsum[9:0]};
    end
  end

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Self-checking bench for logarithmic_afpm: frames operands byte-serially,
// pushes expected products to a scoreboard queue and pops them when the
// result bytes appear on uo_out.
module tb_logarithmic_afpm;

  localparam int unsigned H = 3;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  logic [15:0] sb[$];

  logarithmic_afpm #(.HOLD_CYCLES(H)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; edge k has index edges-1 after it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  // Reference model written from the arithmetic definition
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int   xa, xb, ma, mb, e, m;
    logic s;
    logic [15:0] r;
    s  = a[15] ^ b[15];
    xa = int'(a[14:10]);
    xb = int'(b[14:10]);
    ma = int'(a[9:0]);
    mb = int'(b[9:0]);
    if ((xa == 31 && ma != 0) || (xb == 31 && mb != 0)) return 16'h7E00;
    if ((xa == 31 && xb == 0) || (xb == 31 && xa == 0)) return 16'h7E00;
    if (xa == 31 || xb == 31) return {s, 15'h7C00};
    if (xa == 0 || xb == 0) return {s, 15'h0000};
    m = ma + mb;
    e = xa + xb - 15;
    if (m >= 1024) begin
      e = e + 1;
      m = m - 1024;
    end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0) return {s, 15'h0000};
    r = {s, 5'(e), 10'(m)};
    return r;
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    ui_in  = '0;
    uio_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one full frame starting just before a phase-0 edge; returns
  // uo_out before the load, after the low-byte load and after the high-byte load.
  task automatic drive_frame(input logic [15:0] a, input logic [15:0] b,
                             output logic [7:0] pre, output logic [7:0] lo,
                             output logic [7:0] hi, output int lo_edge);
    ui_in  = a[7:0];
    uio_in = b[7:0];
    @(posedge clk); #1;
    ui_in  = 8'($urandom_range(0, 255));
    uio_in = 8'($urandom_range(0, 255));
    repeat (H - 1) begin @(posedge clk); #1; end
    ui_in  = a[15:8];
    uio_in = b[15:8];
    @(posedge clk); #1;
    ui_in  = 8'($urandom_range(0, 255));
    uio_in = 8'($urandom_range(0, 255));
    pre = uo_out;
    @(posedge clk); #1;
    lo      = uo_out;
    lo_edge = edges - 1;
    repeat (H) begin @(posedge clk); #1; end
    hi = uo_out;
    repeat (H - 1) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    logic [7:0] pre, lo, hi;
    int         le;
    rst_n = 1'b0;
    #3;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %h required %h", uo_out, 8'h00); end
    checks++; if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset_uio_oe: got %h required %h", uio_oe, 8'h00); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out: got %h required %h", uio_out, 8'h00); end
    do_reset();
    // Partial frame, then asynchronous reset while the low byte is showing
    ui_in = 8'h01; uio_in = 8'h00;
    repeat (H) begin @(posedge clk); #1; end
    ui_in = 8'h3C; uio_in = 8'h3C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (uo_out !== 8'h01) begin errors++; $display("FAIL pre_reset_low: got %h required %h", uo_out, 8'h01); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL async_reset_uo: got %h required %h", uo_out, 8'h00); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Counter must restart: a fresh frame from release lands on the usual edges
    sb.push_back(16'hC000);
    drive_frame(16'h3C00, 16'hC000, pre, lo, hi, le);
    begin
      logic [15:0] exp;
      exp = sb.pop_front();
      checks++; if (lo !== exp[7:0]) begin errors++; $display("FAIL restart_low: got %h required %h", lo, exp[7:0]); end
      checks++; if (hi !== exp[15:8]) begin errors++; $display("FAIL restart_high: got %h required %h", hi, exp[15:8]); end
      checks++; if (le !== int'(H + 1)) begin errors++; $display("FAIL restart_edge: got %0d required %0d", le, H + 1); end
    end
  endtask

  task automatic test_carry();
    logic [7:0]  pre, lo, hi;
    logic [15:0] exp;
    int          le;
    do_reset();
    sb.push_back(16'h4400);
    drive_frame(16'h3E00, 16'h4200, pre, lo, hi, le);
    exp = sb.pop_front();
    checks++; if (pre !== 8'h00) begin errors++; $display("FAIL carry_pre: got %h required %h", pre, 8'h00); end
    checks++; if (lo !== exp[7:0]) begin errors++; $display("FAIL carry_low: got %h required %h", lo, exp[7:0]); end
    checks++; if (hi !== exp[15:8]) begin errors++; $display("FAIL carry_high: got %h required %h", hi, exp[15:8]); end
    checks++; if (le !== 4) begin errors++; $display("FAIL carry_latency: got %0d required %0d", le, 4); end
  endtask

  task automatic test_normal();
    logic [15:0] av[2] = '{16'h3C00, 16'h3E00};
    logic [15:0] bv[2] = '{16'hC000, 16'h3C00};
    logic [15:0] ev[2] = '{16'hC000, 16'h3E00};
    logic [7:0]  pre, lo, hi;
    logic [15:0] exp;
    int          le;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ev[i]);
      drive_frame(av[i], bv[i], pre, lo, hi, le);
      exp = sb.pop_front();
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL normal_%0d: got %h required %h", i, {hi, lo}, exp); end
    end
  endtask

  task automatic test_zero_subnormal();
    logic [15:0] av[2] = '{16'h0001, 16'h8000};
    logic [15:0] bv[2] = '{16'h3C00, 16'h3C00};
    logic [15:0] ev[2] = '{16'h0000, 16'h8000};
    logic [7:0]  pre, lo, hi;
    logic [15:0] exp;
    int          le;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ev[i]);
      drive_frame(av[i], bv[i], pre, lo, hi, le);
      exp = sb.pop_front();
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL zero_%0d: got %h required %h", i, {hi, lo}, exp); end
    end
  endtask

  task automatic test_specials();
    logic [15:0] av[4] = '{16'h7C00, 16'h7C00, 16'h7E01, 16'h0000};
    logic [15:0] bv[4] = '{16'h0000, 16'hBC00, 16'h3C00, 16'hFC00};
    logic [15:0] ev[4] = '{16'h7E00, 16'hFC00, 16'h7E00, 16'h7E00};
    logic [7:0]  pre, lo, hi;
    logic [15:0] exp;
    int          le;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ev[i]);
      drive_frame(av[i], bv[i], pre, lo, hi, le);
      exp = sb.pop_front();
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL special_%0d: got %h required %h", i, {hi, lo}, exp); end
    end
  endtask

  task automatic test_range();
    logic [15:0] av[3] = '{16'h7800, 16'h0400, 16'h5BFF};
    logic [15:0] bv[3] = '{16'h7800, 16'h0400, 16'h5801};
    logic [15:0] ev[3] = '{16'h7C00, 16'h0000, 16'h7800};
    logic [7:0]  pre, lo, hi;
    logic [15:0] exp;
    int          le;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ev[i]);
      drive_frame(av[i], bv[i], pre, lo, hi, le);
      exp = sb.pop_front();
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL range_%0d: got %h required %h", i, {hi, lo}, exp); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, exp;
    logic [7:0]  pre, lo, hi;
    int          le;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      sb.push_back(model(a, b));
      drive_frame(a, b, pre, lo, hi, le);
      exp = sb.pop_front();
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL random_%0d a=%h b=%h: got %h required %h", i, a, b, {hi, lo}, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pre, lo, hi;
    logic [15:0] exp;
    int          le;
    do_reset();
    sb.push_back(16'h4400);
    sb.push_back(16'hC000);
    drive_frame(16'h3E00, 16'h4200, pre, lo, hi, le);
    exp = sb.pop_front();
    checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL b2b_first: got %h required %h", {hi, lo}, exp); end
    drive_frame(16'h3C00, 16'hC000, pre, lo, hi, le);
    exp = sb.pop_front();
    checks++; if (pre !== 8'h44) begin errors++; $display("FAIL b2b_hold_high: got %h required %h", pre, 8'h44); end
    checks++; if (lo !== exp[7:0]) begin errors++; $display("FAIL b2b_second_low: got %h required %h", lo, exp[7:0]); end
    checks++; if (hi !== exp[15:8]) begin errors++; $display("FAIL b2b_second_high: got %h required %h", hi, exp[15:8]); end
    checks++; if (le !== 14) begin errors++; $display("FAIL b2b_edge: got %0d required %0d", le, 14); end
  endtask

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = '0;
    uio_in = '0;
    test_reset();
    test_carry();
    test_normal();
    test_zero_subnormal();
    test_specials();
    test_range();
    test_random();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d required %0d", sb.size(), 0); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
